// File: rtl/ising_pkg.sv
// Shared types and constants for the oscillator-array run controller.
package ising_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StRun,
        StSample,
        StDone
    } run_state_e;

    localparam int unsigned START_BIT = 0;
    localparam int unsigned ABORT_BIT = 1;

    localparam logic [31:0] DEFAULT_RUN_TIME = 32'd1024;

    // Bits needed to hold values 0..value-1; never less than 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/spin_sync.sv
// N-bit two-flop synchronizer for the free-running oscillator outputs.
module spin_sync #(
    parameter int unsigned N = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/anneal_run_ctrl.sv
// Sequences one annealing run: hold oscillators in reset, let them run, then
// majority-vote each spin's phase against spin 0 over several samples.
module anneal_run_ctrl
    import ising_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned RST_CYCLES  = 16,
    parameter int unsigned NUM_SAMPLES = 7,
    parameter int unsigned SAMPLE_GAP  = 3,
    parameter logic [31:0] CTRL_ADDR   = 32'h0000_0000,
    parameter logic [31:0] TIME_ADDR   = 32'h0000_0004
) (
    input  logic         clk,
    input  logic         axi_rstn,
    input  logic         wready,
    input  logic [31:0]  wr_addr,
    input  logic [31:0]  wdata,
    input  logic [N-1:0] spin_in,
    output logic         osc_rstn,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic [31:0]  cycles_run
);

    localparam int unsigned SW = clog2(NUM_SAMPLES + 1);
    localparam int unsigned GW = clog2(SAMPLE_GAP);
    localparam int unsigned RW = clog2(RST_CYCLES);

    localparam logic [SW-1:0] NumSamplesL = SW'(NUM_SAMPLES);
    localparam logic [SW-1:0] HalfL       = SW'(NUM_SAMPLES / 2);
    localparam logic [GW-1:0] GapLast     = GW'(SAMPLE_GAP - 1);
    localparam logic [RW-1:0] RstLast     = RW'(RST_CYCLES - 1);

    run_state_e            state_q, state_d;
    logic [31:0]           run_time_q, run_time_d;
    logic [31:0]           cycles_run_q, cycles_run_d;
    logic [RW-1:0]         rst_cnt_q, rst_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [SW-1:0]         samp_cnt_q, samp_cnt_d;
    logic [N-1:0][SW-1:0]  agree_q, agree_d;
    logic                  osc_rstn_q, osc_rstn_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [N-1:0]          result_q, result_d;

    logic [N-1:0] spin_s;
    logic         ctrl_wr;
    logic         start_req;
    logic         abort_req;
    logic         time_wr;
    logic [31:0]  run_time_eff;

    spin_sync #(
        .N (N)
    ) u_spin_sync (
        .clk_i  (clk),
        .rst_ni (axi_rstn),
        .d_i    (spin_in),
        .q_o    (spin_s)
    );

    assign ctrl_wr      = wready && (wr_addr == CTRL_ADDR);
    assign abort_req    = ctrl_wr && wdata[ABORT_BIT];
    assign start_req    = ctrl_wr && wdata[START_BIT] && !wdata[ABORT_BIT];
    assign time_wr      = wready && (wr_addr == TIME_ADDR) && !busy_q;
    assign run_time_eff = (run_time_q == 32'd0) ? 32'd1 : run_time_q;

    always_comb begin
        state_d      = state_q;
        run_time_d   = time_wr ? wdata : run_time_q;
        cycles_run_d = cycles_run_q;
        rst_cnt_d    = rst_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        agree_d      = agree_q;
        busy_d       = busy_q;
        done_d       = done_q;
        result_d     = result_q;

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    state_d      = StReset;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    result_d     = '0;
                    cycles_run_d = '0;
                    agree_d      = '0;
                    rst_cnt_d    = '0;
                end
            end
            StReset: begin
                if (rst_cnt_q == RstLast) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            StRun: begin
                cycles_run_d = cycles_run_q + 32'd1;
                if (cycles_run_d >= run_time_eff) begin
                    state_d    = StSample;
                    gap_cnt_d  = '0;
                    samp_cnt_d = '0;
                end
            end
            StSample: begin
                // One idle cycle after the final sample before results are voted.
                if (samp_cnt_q == NumSamplesL) begin
                    state_d = StDone;
                end else if (gap_cnt_q == '0) begin
                    samp_cnt_d = samp_cnt_q + SW'(1);
                    gap_cnt_d  = GapLast;
                    for (int i = 0; i < N; i++) begin
                        if ((spin_s[i] == spin_s[0]) && (agree_q[i] != NumSamplesL)) begin
                            agree_d[i] = agree_q[i] + SW'(1);
                        end
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GW'(1);
                end
            end
            StDone: begin
                for (int i = 0; i < N; i++) begin
                    result_d[i] = (agree_q[i] > HalfL);
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort discards the run but leaves cycles_run as evidence of how far it got.
        if (abort_req && (state_q inside {StReset, StRun, StSample})) begin
            state_d      = StIdle;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            result_d     = '0;
            cycles_run_d = cycles_run_q;
        end

        osc_rstn_d = (state_d == StRun) || (state_d == StSample);
    end

    always_ff @(posedge clk) begin
        if (!axi_rstn) begin
            state_q      <= StIdle;
            run_time_q   <= DEFAULT_RUN_TIME;
            cycles_run_q <= '0;
            rst_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            samp_cnt_q   <= '0;
            agree_q      <= '0;
            osc_rstn_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            run_time_q   <= run_time_d;
            cycles_run_q <= cycles_run_d;
            rst_cnt_q    <= rst_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            agree_q      <= agree_d;
            osc_rstn_q   <= osc_rstn_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

    assign osc_rstn   = osc_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign cycles_run = cycles_run_q;

endmodule

// File: tb/tb_anneal_run_ctrl.sv
// Directed bench for anneal_run_ctrl; completed runs are checked by a scoreboard monitor.
module tb_anneal_run_ctrl;

    localparam int RST  = 16;
    localparam int NS   = 7;
    localparam int GAP  = 3;
    localparam logic [31:0] CTRL = 32'h0000_0000;
    localparam logic [31:0] TIME = 32'h0000_0004;

    logic        clk = 1'b0;
    logic        axi_rstn;
    logic        wready;
    logic [31:0] wr_addr;
    logic [31:0] wdata;
    logic [7:0]  spin_in;
    logic        osc_rstn;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic [31:0] cycles_run;

    always #5 clk = ~clk;

    anneal_run_ctrl u_dut (
        .clk        (clk),
        .axi_rstn   (axi_rstn),
        .wready     (wready),
        .wr_addr    (wr_addr),
        .wdata      (wdata),
        .spin_in    (spin_in),
        .osc_rstn   (osc_rstn),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cycles_run (cycles_run)
    );

    typedef struct {
        logic [7:0]  res;
        logic [31:0] cyc_run;
        int          lat;
        int          t0;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising edge of done must match the oldest pending run.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1 && done_prev !== 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got done with no run pending, expected none");
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("cycles_run", cycles_run, e.cyc_run);
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                    check("busy_at_done", 32'(busy), 32'd0);
                    check("osc_rstn_at_done", 32'(osc_rstn), 32'd0);
                end
            end
            done_prev = done;
        end
    end

    // Called at a negedge; the write is taken on the next posedge, returns at the negedge after.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wready  = 1'b1;
        wr_addr = a;
        wdata   = d;
        @(negedge clk);
        wready  = 1'b0;
        wr_addr = '0;
        wdata   = '0;
    endtask

    task automatic start_expect(input logic [7:0] res, input int rt);
        int   rt_eff;
        exp_t e;
        rt_eff = (rt == 0) ? 1 : rt;
        wr(CTRL, 32'h1);
        e.res     = res;
        e.cyc_run = 32'(rt_eff);
        e.lat     = RST + rt_eff + (NS - 1) * GAP + 3;
        e.t0      = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL run_timeout: %0d runs still pending, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Drive sample k's spin pattern so the synchronized value lands on the k-th sample edge.
    task automatic drive_samples(input int rt, input logic [6:0] m);
        repeat (RST + rt - 2) @(posedge clk);
        #1 spin_in = {4'b0000, m[0], 3'b001};
        for (int k = 1; k < NS; k++) begin
            repeat (GAP) @(posedge clk);
            #1 spin_in = {4'b0000, m[k], 3'b001};
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_rstn = 1'b0;
        wready   = 1'b0;
        wr_addr  = '0;
        wdata    = '0;
        spin_in  = '0;
        repeat (3) @(negedge clk);
        check("rst_osc_rstn", 32'(osc_rstn), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cycles_run", cycles_run, 32'd0);
        axi_rstn = 1'b1;
        @(negedge clk);

        // Static phases: each spin's result equals its own value since spin 0 is 1.
        spin_in = 8'hAB;
        wr(TIME, 32'd10);
        start_expect(8'hAB, 10);
        @(negedge clk);
        check("busy_after_start", 32'(busy), 32'd1);
        check("osc_rstn_in_reset", 32'(osc_rstn), 32'd0);
        repeat (14) @(negedge clk);
        check("osc_rstn_last_reset", 32'(osc_rstn), 32'd0);
        @(negedge clk);
        check("osc_rstn_first_run", 32'(osc_rstn), 32'd1);
        wait_idle(200);
        check("done_held_idle", 32'(done), 32'd1);

        // Majority: spin 3 agrees on 4 of 7 samples, then on 3 of 7.
        spin_in = 8'h01;
        start_expect(8'h09, 10);
        drive_samples(10, 7'b1010101);
        wait_idle(200);
        spin_in = 8'h01;
        start_expect(8'h01, 10);
        drive_samples(10, 7'b0101010);
        wait_idle(200);

        // Abort in RUN after 5 cycles, then a clean run.
        spin_in = 8'h01;
        wr(TIME, 32'd20);
        wr(CTRL, 32'h1);
        repeat (21) @(negedge clk);
        check("osc_rstn_before_abort", 32'(osc_rstn), 32'd1);
        check("cycles_before_abort", cycles_run, 32'd5);
        wr(CTRL, 32'h2);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_osc_rstn", 32'(osc_rstn), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cycles_kept", cycles_run, 32'd5);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);
        start_expect(8'h01, 20);
        wait_idle(200);

        // Start+abort together from idle does not start a run.
        wr(CTRL, 32'h3);
        check("start_abort_busy", 32'(busy), 32'd0);

        // TIME and start writes while busy are ignored.
        start_expect(8'h01, 20);
        repeat (3) @(negedge clk);
        wr(TIME, 32'd50);
        wr(CTRL, 32'h1);
        wait_idle(200);

        // TIME=0 runs for one cycle.
        wr(TIME, 32'd0);
        start_expect(8'h01, 0);
        wait_idle(200);

        // Reset during SAMPLE, then a run with the default run time.
        wr(TIME, 32'd10);
        wr(CTRL, 32'h1);
        repeat (28) @(negedge clk);
        check("busy_in_sample", 32'(busy), 32'd1);
        check("osc_rstn_in_sample", 32'(osc_rstn), 32'd1);
        axi_rstn = 1'b0;
        @(negedge clk);
        check("midrst_osc_rstn", 32'(osc_rstn), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_cycles_run", cycles_run, 32'd0);
        axi_rstn = 1'b1;
        @(negedge clk);
        start_expect(8'h01, 1024);
        wait_idle(1300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
